// File: rtl/cdma_decoder.sv
// cdma_decoder: de-spreads per-bit chip sums with its own code, one word per code period.
// Define CDMA_DECODER_AMBIG_EN to flag zero-correlation bits on ambiguous.
package AggrCDMAPkg;
  localparam int DATA_WIDTH = 8;
  localparam int COUNTER_WIDTH = 4;
  localparam int CDMA_CODE_WIDTH = 4;
  localparam int CDMA_CODE_NUM = 4;
  localparam logic [CDMA_CODE_NUM-1:0][CDMA_CODE_WIDTH-1:0] CDMA_CODES = {4'b1001, 4'b0110, 4'b1100, 4'b1010};
endpackage

module cdma_decoder
  import AggrCDMAPkg::*;
#(
  parameter int CODE_NUM = 0,
  parameter int SUM_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rotate_code,
  input  logic [COUNTER_WIDTH-1:0]             counter,
  input  logic [DATA_WIDTH-1:0][SUM_WIDTH-1:0] chip_sum,
  output logic [DATA_WIDTH-1:0]                decoded,
  output logic                                 valid,
  output logic                                 locked,
  output logic [DATA_WIDTH-1:0]                ambiguous
);
  localparam int ACC_WIDTH = SUM_WIDTH + $clog2(CDMA_CODE_WIDTH) + 1;
  localparam int IDX_WIDTH = $clog2(CDMA_CODE_WIDTH) + 1;
  localparam logic [0:0] WAIT_SYNC = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic [CDMA_CODE_WIDTH-1:0] code_reg;
  logic [IDX_WIDTH-1:0] chip_idx;
  logic signed [ACC_WIDTH-1:0] acc [DATA_WIDTH];
  logic signed [ACC_WIDTH-1:0] s [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] neg;
  logic sync, step, last;
  assign sync = &counter;
  assign step = state == RUN && rotate_code && !sync;
  assign last = chip_idx == IDX_WIDTH'(CDMA_CODE_WIDTH - 1);
  assign locked = state == RUN;
  // s is the running correlation including the chip being sampled this cycle
  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) begin
      s[i] = code_reg[0] ? acc[i] + $signed(ACC_WIDTH'(chip_sum[i])) : acc[i] - $signed(ACC_WIDTH'(chip_sum[i]));
      neg[i] = s[i][ACC_WIDTH-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_SYNC;
      code_reg <= CDMA_CODES[CODE_NUM];
      chip_idx <= '0;
      acc <= '{default: '0};
      decoded <= '0;
      valid <= 1'b0;
    end else begin
      valid <= step && last;
      if (sync) begin
        state <= RUN;
        code_reg <= CDMA_CODES[CODE_NUM];
        chip_idx <= '0;
        acc <= '{default: '0};
      end else if (step) begin
        code_reg <= {code_reg[0], code_reg[CDMA_CODE_WIDTH-1:1]};
        chip_idx <= last ? '0 : chip_idx + 1'b1;
        for (int i = 0; i < DATA_WIDTH; i++) acc[i] <= last ? '0 : s[i];
        if (last) decoded <= neg;
      end
    end
  end
`ifdef CDMA_DECODER_AMBIG_EN
  logic [DATA_WIDTH-1:0] zero;
  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) zero[i] = s[i] == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ambiguous <= '0;
    else if (step && last) ambiguous <= zero;
  end
`else
  assign ambiguous = '0;
`endif
endmodule

// File: tb/tb_cdma_decoder.sv
// tb_cdma_decoder: two decoders (codes 0 and 1) against a per-frame correlation model with random multi-user traffic.
module tb_cdma_decoder;
  import AggrCDMAPkg::*;
  typedef logic [DATA_WIDTH-1:0][3:0] cs_t;
`ifdef CDMA_DECODER_AMBIG_EN
  localparam bit AMB = 1'b1;
`else
  localparam bit AMB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rotate_code = 1'b0;
  logic [COUNTER_WIDTH-1:0] counter = '0;
  cs_t chip_sum = '0;
  logic [7:0] dec [2];
  logic [7:0] amb [2];
  logic val [2];
  logic lck [2];
  int checks = 0;
  int errors = 0;
  int m_sum [2][8];
  int m_k = 0;
  bit m_locked = 1'b0;
  logic [7:0] n_dec [2] = '{default: '0};
  logic [7:0] n_amb [2] = '{default: '0};
  bit n_valid = 1'b0, n_lck = 1'b0;
  logic [7:0] e_dec [2] = '{default: '0};
  logic [7:0] e_amb [2] = '{default: '0};
  bit e_valid = 1'b0, e_lck = 1'b0;

  cdma_decoder #(.CODE_NUM(0), .SUM_WIDTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .rotate_code(rotate_code), .counter(counter), .chip_sum(chip_sum),
    .decoded(dec[0]), .valid(val[0]), .locked(lck[0]), .ambiguous(amb[0])
  );
  cdma_decoder #(.CODE_NUM(1), .SUM_WIDTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .rotate_code(rotate_code), .counter(counter), .chip_sum(chip_sum),
    .decoded(dec[1]), .valid(val[1]), .locked(lck[1]), .ambiguous(amb[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", n, got, want, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 1'b0;
      e_lck <= 1'b0;
      e_dec <= '{default: '0};
      e_amb <= '{default: '0};
    end else begin
      e_valid <= n_valid;
      e_lck <= n_lck;
      e_dec <= n_dec;
      e_amb <= n_amb;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("cyc_valid%0d", d), 8'(val[d]), 8'(e_valid));
      chk($sformatf("cyc_locked%0d", d), 8'(lck[d]), 8'(e_lck));
      chk($sformatf("cyc_decoded%0d", d), dec[d], e_dec[d]);
      chk($sformatf("cyc_ambig%0d", d), amb[d], e_amb[d]);
    end
  end

  task automatic clr_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) m_sum[d][i] = 0;
  endtask

  // drive one cycle of inputs and advance the model to what the next edge must produce
  task automatic drive(input bit rot, input bit sync, input cs_t cs);
    @(negedge clk);
    rotate_code = rot;
    counter = sync ? '1 : 4'($urandom_range(0, 14));
    chip_sum = cs;
    n_valid = 1'b0;
    if (sync) begin
      m_locked = 1'b1;
      m_k = 0;
      clr_model();
    end else if (m_locked && rot) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 8; i++) m_sum[d][i] += CDMA_CODES[d][m_k] ? int'(cs[i]) : -int'(cs[i]);
      m_k++;
      if (m_k == CDMA_CODE_WIDTH) begin
        n_valid = 1'b1;
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < 8; i++) begin
            n_dec[d][i] = m_sum[d][i] < 0;
            n_amb[d][i] = AMB && m_sum[d][i] == 0;
          end
        clr_model();
        m_k = 0;
      end
    end
    n_lck = m_locked;
  endtask

  function automatic cs_t rand_cs();
    cs_t c;
    for (int i = 0; i < 8; i++) c[i] = 4'($urandom_range(0, 15));
    return c;
  endfunction

  function automatic cs_t enc(input logic [7:0] d0, d1, d2, input logic [2:0] act, input int k);
    cs_t c;
    logic [7:0] dv [3];
    dv[0] = d0; dv[1] = d1; dv[2] = d2;
    for (int i = 0; i < 8; i++) begin
      c[i] = '0;
      for (int u = 0; u < 3; u++)
        if (act[u]) c[i] += 4'(dv[u][i] ^ CDMA_CODES[u][k]);
    end
    return c;
  endfunction

  task automatic frame(input logic [7:0] d0, d1, d2, input logic [2:0] act, input int gaps);
    for (int k = 0; k < CDMA_CODE_WIDTH; k++) begin
      repeat ($urandom_range(0, gaps)) drive(1'b0, 1'b0, rand_cs());
      drive(1'b1, 1'b0, enc(d0, d1, d2, act, k));
    end
  endtask

  task automatic settle();
    drive(1'b0, 1'b0, '0);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rotate_code = 1'b0;
    counter = '0;
    m_locked = 1'b0;
    m_k = 0;
    clr_model();
    n_valid = 1'b0;
    n_lck = 1'b0;
    n_dec = '{default: '0};
    n_amb = '{default: '0};
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 8'(val[0]), 8'h00);
    chk("rst_locked", 8'(lck[0]), 8'h00);
    chk("rst_decoded", dec[0], 8'h00);
    chk("rst_ambig", amb[0], 8'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("init_locked", 8'(lck[0]), 8'h00);
    chk("init_valid", 8'(val[0]), 8'h00);
    #1;
    rst_n = 1'b1;
    repeat (8) drive(1'b1, 1'b0, rand_cs());
    settle();
    chk("presync_locked", 8'(lck[0]), 8'h00);
    chk("presync_valid", 8'(val[0]), 8'h00);
    drive(1'b0, 1'b1, '0);
    settle();
    chk("sync_locked", 8'(lck[0]), 8'h01);
    frame(8'hA5, 8'h00, 8'h00, 3'b001, 0);
    settle();
    chk("single_valid", 8'(val[0]), 8'h01);
    chk("single_word", dec[0], 8'hA5);
    frame(8'hFF, 8'h00, 8'h00, 3'b011, 2);
    settle();
    chk("two_user_code0", dec[0], 8'hFF);
    chk("two_user_code1", dec[1], 8'h00);
    chk("two_user_valid", 8'(val[1]), 8'h01);
    drive(1'b1, 1'b0, enc(8'h81, 8'h00, 8'h00, 3'b001, 0));
    drive(1'b1, 1'b0, enc(8'h81, 8'h00, 8'h00, 3'b001, 1));
    drive(1'b1, 1'b1, enc(8'h81, 8'h00, 8'h00, 3'b001, 2));
    frame(8'h3C, 8'hC3, 8'h00, 3'b011, 1);
    settle();
    chk("resync_word0", dec[0], 8'h3C);
    chk("resync_word1", dec[1], 8'hC3);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, enc(8'h77, 8'h00, 8'h00, 3'b001, k));
    do_reset();
    frame(8'h11, 8'h00, 8'h00, 3'b001, 0);
    settle();
    chk("post_rst_nosync_valid", 8'(val[0]), 8'h00);
    drive(1'b0, 1'b1, '0);
    frame(8'h5A, 8'h00, 8'h00, 3'b001, 0);
    settle();
    chk("post_rst_word", dec[0], 8'h5A);
    frame(8'h00, 8'h00, 8'h00, 3'b000, 0);
    settle();
    chk("zero_valid", 8'(val[0]), 8'h01);
    chk("zero_decoded", dec[0], 8'h00);
    chk("zero_ambig", amb[0], AMB ? 8'hFF : 8'h00);
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 3)) drive(1'b1, 1'b0, rand_cs());
        drive(1'($urandom_range(0, 1)), 1'b1, rand_cs());
      end
      frame(8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 2);
    end
    repeat (3) drive(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdma_decoder.md
# cdma_decoder

Receive-side counterpart of the per-port CDMA encoder in the aggregated-CDMA crossbar. It sits at a crossbar output and takes the per-bit chip sums of all encoders sharing the medium. It correlates those sums with its own spreading code over one code period and emits one de-spread data word per period, aligned to the crossbar's `counter` / `rotate_code` frame timing.

## Interface
Parameters:
- `CODE_NUM`, default 0: index into `CDMA_CODES` from `AggrCDMAPkg`; must match the transmitting encoder's `CODE_NUM`.
- `SUM_WIDTH`, default 4: unsigned width of each per-bit chip sum (maximum number of summed encoders is 2^SUM_WIDTH−1).
- `ACC_WIDTH`, derived, not overridable: SUM_WIDTH + $clog2(CDMA_CODE_WIDTH) + 1, signed.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rotate_code`  in  1  chip strobe; same signal that drives the encoders.
- `counter`  in  COUNTER_WIDTH  frame counter; all-ones marks frame restart.
- `chip_sum`  in  [DATA_WIDTH-1:0][SUM_WIDTH-1:0]  per-bit unsigned count of encoders driving 1 in this chip.
- `decoded`  out  DATA_WIDTH  recovered data word.
- `valid`  out  1  one-cycle pulse; `decoded` is new.
- `locked`  out  1  high once the first frame sync has been seen.
- `ambiguous`  out  DATA_WIDTH  per-bit zero-correlation flag (see Configuration).

## Operation
- FSM states:
  - `WAIT_SYNC` (reset state).
  - `RUN`.
- Transitions:
  - `WAIT_SYNC` → `RUN` when `counter` is all-ones.
  - There is no return to `WAIT_SYNC` except via `rst_n`.
- Internal registers:
  - `code_reg` [CDMA_CODE_WIDTH].
  - `acc[DATA_WIDTH]` [ACC_WIDTH] signed.
  - `chip_idx` [$clog2(CDMA_CODE_WIDTH)+1].
- Frame restart (`counter` all-ones, any state):
  - `code_reg` <= CDMA_CODES[CODE_NUM].
  - All `acc` <= 0.
  - `chip_idx` <= 0.
  - Any partial frame is discarded without a `valid`.
  - Restart has priority over a simultaneous `rotate_code`.
- Chip step (`RUN`, `rotate_code`=1, no restart):
  - The current chip is c = `code_reg[0]`.
  - Per bit i: `acc[i]` += c ? +chip_sum[i] : −chip_sum[i]. `chip_sum[i]` is zero-extended before negation.
  - `code_reg` rotates right, exactly as in the encoder: {code_reg[0], code_reg[W-1:1]}.
  - `chip_idx`++.
- In `WAIT_SYNC`, `rotate_code` is ignored.
- Decision:
  - On the chip step where `chip_idx` = CDMA_CODE_WIDTH−1, compute the final sum s_i = acc[i] + contribution.
  - `decoded[i]` <= (s_i < 0).
  - `valid` <= 1.
  - All `acc` <= 0 and `chip_idx` <= 0; the next frame's chips accumulate immediately.
- Rationale: codes are balanced and orthogonal, so other users contribute 0. Own bit 0 yields +W/2; own bit 1 yields −W/2.
- No overflow can occur: |acc| ≤ CDMA_CODE_WIDTH·(2^SUM_WIDTH−1), which fits ACC_WIDTH.
- There is no backpressure. The consumer must take `decoded` on the `valid` cycle; `decoded` holds until the next decision.

## Timing
- Reset values:
  - `decoded`=0, `valid`=0, `locked`=0, `ambiguous`=0.
  - `acc`=0, `chip_idx`=0.
  - `code_reg`=CDMA_CODES[CODE_NUM].
  - State `WAIT_SYNC`.
- `locked` rises one cycle after the first all-ones `counter` is sampled.
- `chip_sum` is sampled in the same cycle as `rotate_code`. This aligns with the encoder's combinational `encoded` for that chip.
- Latency: `valid` is high the cycle after the rising edge that samples the last (W-th) chip strobe.
- Gaps between `rotate_code` strobes are allowed; accumulation simply waits.
- `rst_n` deasserted mid-frame clears everything asynchronously. Decoding resumes only after the next frame sync.

## Configuration
- `CDMA_DECODER_AMBIG_EN` defined:
  - `ambiguous[i]` <= (s_i == 0) at each decision, registered with `decoded`.
  - `decoded[i]` is 0 for ambiguous bits.
- `CDMA_DECODER_AMBIG_EN` undefined:
  - The zero-compare logic is not built.
  - The `ambiguous` port remains and is tied to 0.

## Test plan
- Single user, code 4'b1010 (W=4), data 8'hA5, `chip_sum[i]` = encoder `encoded[i]` over 4 strobes after sync. Required:
  - `valid` pulse one cycle after the 4th strobe.
  - `decoded`=8'hA5.
- Two users on orthogonal codes 4'b1010 and 4'b1100, data 8'hFF and 8'h00, `chip_sum` = per-bit sum. Required:
  - Decoder with CODE_NUM for 4'b1010 gives 8'hFF.
  - Decoder with CODE_NUM for 4'b1100 gives 8'h00.
- Sync during frame: all-ones `counter` after 2 strobes, coinciding with a 3rd `rotate_code`. Required:
  - No `valid` for the partial frame.
  - The next full 4 strobes yield the correct word.
- Before sync: 8 `rotate_code` strobes with `counter` ≠ all-ones after reset. Required:
  - `valid` stays 0 and `locked` stays 0.
  - After sync, `locked`=1 the next cycle.
- `rst_n` asserted for 1 cycle after the 3rd strobe. Required:
  - All outputs 0 immediately.
  - No `valid` until the sync + 4 strobes that follow.
- `chip_sum` all zeros for a frame, with `CDMA_DECODER_AMBIG_EN` defined. Required:
  - `decoded`=8'h00 and `ambiguous`=8'hFF.
  - With the macro undefined: `ambiguous`=8'h00.
